// File: rtl/scan_sequencer_if.sv
// rtl/scan_sequencer_if.sv - host/datapath bundle for the NMR scan sequencer
// Purpose: groups the sequencer's configuration, control and status signals.
// Ports (via modports):
//   master : drives cfg_we/cfg_addr/cfg_wdata, num_scans, cycle_len, scan_len,
//            rep_delay, start, abort; observes the status/output signals
//   slave  : the sequencer; observes the controls, drives enable_PC,
//            TX_phase_data, RX_phase_data, scan_idx, busy, done, err_cfg
interface scan_sequencer_if #(
  parameter int PC_DEPTH = 4,
  parameter int CNT_W    = 32,
  parameter int SCAN_W   = 16
);
  localparam int PCW = $clog2(PC_DEPTH);

  logic              cfg_we;
  logic [PCW-1:0]    cfg_addr;
  logic [19:0]       cfg_wdata;
  logic [SCAN_W-1:0] num_scans;
  logic [PCW:0]      cycle_len;
  logic [CNT_W-1:0]  scan_len;
  logic [CNT_W-1:0]  rep_delay;
  logic              start;
  logic              abort;
  logic              enable_PC;
  logic [14:0]       TX_phase_data;
  logic [4:0]        RX_phase_data;
  logic [SCAN_W-1:0] scan_idx;
  logic              busy;
  logic              done;
  logic              err_cfg;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, num_scans, cycle_len, scan_len,
           rep_delay, start, abort,
    input  enable_PC, TX_phase_data, RX_phase_data, scan_idx, busy, done,
           err_cfg
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, num_scans, cycle_len, scan_len,
           rep_delay, start, abort,
    output enable_PC, TX_phase_data, RX_phase_data, scan_idx, busy, done,
           err_cfg
  );
endinterface

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - scan-level scheduler: scan count, phase cycling, enable envelope
// Purpose: runs num_scans scans; each scan presents a phase-table entry, raises
//   enable_PC for scan_len cycles, then holds it low for rep_delay cycles.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : scan_sequencer_if.slave (config/table write/start/abort in,
//           enable_PC, phase words, scan_idx, busy, done, err_cfg out)
module scan_sequencer #(
  parameter int PC_DEPTH = 4,
  parameter int CNT_W    = 32,
  parameter int SCAN_W   = 16
) (
  input  logic clk,
  input  logic rst_n,
  scan_sequencer_if.slave bus
);
  localparam int PCW = $clog2(PC_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_DELAY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SCAN_W-1:0] num_q, num_d;
  logic [PCW:0]      clen_q, clen_d;
  logic [CNT_W-1:0]  slen_q, slen_d;
  logic [CNT_W-1:0]  rdly_q, rdly_d;
  logic [PCW-1:0]    p_q, p_d;
  logic [SCAN_W-1:0] idx_q, idx_d;
  logic [14:0]       tx_q, tx_d;
  logic [4:0]        rx_q, rx_d;
  logic              en_q, en_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [19:0]       pc_tbl_q [PC_DEPTH];

  logic              wr_ok, start_ok, run_exp, dly_exp, last_scan;
  logic [PCW:0]      p_inc, clen_eff;
  logic [19:0]       arm_entry;

  // Table writes are only taken while no sequence is in flight.
  assign wr_ok     = bus.cfg_we && !busy_q;
  assign start_ok  = bus.start && !bus.abort && (state_q == S_IDLE);
  assign run_exp   = (state_q == S_RUN) && (cnt_q == slen_q - CNT_W'(1));
  assign dly_exp   = (state_q == S_DELAY) && (cnt_q == rdly_q - CNT_W'(1));
  assign last_scan = (idx_q == num_q - SCAN_W'(1));
  assign p_inc     = {1'b0, p_q} + (PCW+1)'(1);

  always_comb begin
    if (bus.cycle_len == '0)                       clen_eff = (PCW+1)'(1);
    else if (bus.cycle_len > (PCW+1)'(PC_DEPTH))   clen_eff = (PCW+1)'(PC_DEPTH);
    else                                           clen_eff = bus.cycle_len;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start_ok && bus.scan_len != '0)
                  state_d = (bus.num_scans == '0) ? S_DONE : S_ARM;
        S_ARM:   state_d = S_RUN;
        S_RUN:   if (run_exp)
                   state_d = last_scan ? S_DONE : ((rdly_q == '0) ? S_ARM : S_DELAY);
        S_DELAY: if (dly_exp) state_d = S_ARM;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output / datapath next-values
  always_comb begin
    cnt_d  = cnt_q;
    num_d  = num_q;
    clen_d = clen_q;
    slen_d = slen_q;
    rdly_d = rdly_q;
    p_d    = p_q;
    idx_d  = idx_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    err_d  = start_ok && (bus.scan_len == '0);
    if (bus.abort) begin
      cnt_d = '0;
      p_d   = '0;
      idx_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (start_ok && bus.scan_len != '0) begin
          num_d  = bus.num_scans;
          clen_d = clen_eff;
          slen_d = bus.scan_len;
          rdly_d = bus.rep_delay;
          idx_d  = '0;
          p_d    = '0;
          cnt_d  = '0;
        end
        S_RUN: if (run_exp) begin
          cnt_d = '0;
          if (!last_scan) begin
            idx_d = idx_q + SCAN_W'(1);
            p_d   = (p_inc == clen_q) ? '0 : p_inc[PCW-1:0];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        S_DELAY: cnt_d = dly_exp ? '0 : cnt_q + CNT_W'(1);
        default: ;
      endcase
    end
    // Phase is loaded on entry to ARM so it is stable a full cycle before
    // enable_PC rises; a table write accepted on the same edge is forwarded.
    arm_entry = (wr_ok && bus.cfg_addr == p_d) ? bus.cfg_wdata : pc_tbl_q[p_d];
    if (state_d == S_ARM) begin
      tx_d = arm_entry[19:5];
      rx_d = arm_entry[4:0];
    end
    en_d   = (state_d == S_RUN);
    busy_d = (state_d == S_ARM) || (state_d == S_RUN) || (state_d == S_DELAY);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      num_q    <= '0;
      clen_q   <= '0;
      slen_q   <= '0;
      rdly_q   <= '0;
      p_q      <= '0;
      idx_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      pc_tbl_q <= '{default: '0};
    end else begin
      cnt_q  <= cnt_d;
      num_q  <= num_d;
      clen_q <= clen_d;
      slen_q <= slen_d;
      rdly_q <= rdly_d;
      p_q    <= p_d;
      idx_q  <= idx_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      en_q   <= en_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
      if (wr_ok) pc_tbl_q[bus.cfg_addr] <= bus.cfg_wdata;
    end
  end

  assign bus.enable_PC     = en_q;
  assign bus.TX_phase_data = tx_q;
  assign bus.RX_phase_data = rx_q;
  assign bus.scan_idx      = idx_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err_cfg       = err_q;
endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - scoreboard bench for scan_sequencer
module tb_scan_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scan_sequencer_if bus ();
  scan_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // kind: 0 = enable pulse, 1 = done pulse, 2 = err_cfg pulse; gap < 0 = don't care
  typedef struct {
    int          kind;
    int          idx;
    logic [19:0] ph;
    int          len;
    int          gap;
  } evt_t;

  evt_t        exp_q[$];
  logic [19:0] model_tbl [4];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  task automatic push_evt(int kind, int idx, logic [19:0] ph, int len, int gap);
    evt_t e;
    e.kind = kind; e.idx = idx; e.ph = ph; e.len = len; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: scan k uses table entry k mod effective cycle length.
  task automatic model_seq(int num, int cl, int slen, int rdly, int ab_pulse, int ab_len);
    int eff;
    eff = (cl == 0) ? 1 : ((cl > 4) ? 4 : cl);
    if (slen == 0) begin
      push_evt(2, 0, 20'h0, 0, -1);
      return;
    end
    for (int k = 0; k < num; k++) begin
      if (k == ab_pulse) begin
        push_evt(0, k, model_tbl[2'(k % eff)], ab_len, (k == 0) ? -1 : rdly + 1);
        return;
      end
      push_evt(0, k, model_tbl[2'(k % eff)], slen, (k == 0) ? -1 : rdly + 1);
    end
    push_evt(1, 0, 20'h0, 0, (num == 0) ? -1 : 1);
  endtask

  task automatic check_evt(int kind, int idx, logic [19:0] ph, logic [19:0] pre,
                           int len, int gap, bit ok);
    evt_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d idx=%0d ph=%h len=%0d expected none", kind, idx, ph, len);
      return;
    end
    e = exp_q.pop_front();
    if (kind != e.kind || !ok ||
        (kind == 0 && (idx != e.idx || ph != e.ph || pre != e.ph || len != e.len)) ||
        (e.gap >= 0 && gap != e.gap)) begin
      errors++;
      $display("FAIL event kind=%0d idx=%0d ph=%h pre=%h len=%0d gap=%0d ok=%0d expected kind=%0d idx=%0d ph=%h len=%0d gap=%0d ok=1",
               kind, idx, ph, pre, len, gap, ok, e.kind, e.idx, e.ph, e.len, e.gap);
    end
  endtask

  // Monitor: turns DUT output activity into events and checks them against the queue.
  int          low_run = 0, cur_len = 0, cur_idx = 0, cur_gap = 0;
  logic [19:0] mon_ph, cur_ph, cur_pre, prev_ph = 20'h0;
  bit          in_pulse = 1'b0, cur_ok = 1'b1;

  initial forever begin
    @(negedge clk);
    mon_ph = {bus.TX_phase_data, bus.RX_phase_data};
    if (!mon_en) begin
      in_pulse = 1'b0;
      low_run  = 0;
    end else begin
      if (bus.enable_PC) begin
        if (!in_pulse) begin
          in_pulse = 1'b1;
          cur_len  = 0;
          cur_idx  = int'(bus.scan_idx);
          cur_ph   = mon_ph;
          cur_pre  = prev_ph;
          cur_gap  = low_run;
          cur_ok   = 1'b1;
        end
        cur_len++;
        if (!bus.busy || mon_ph != cur_ph) cur_ok = 1'b0;
      end else begin
        if (in_pulse) begin
          check_evt(0, cur_idx, cur_ph, cur_pre, cur_len, cur_gap, cur_ok);
          in_pulse = 1'b0;
          low_run  = 0;
        end
        low_run++;
      end
      if (bus.done)    check_evt(1, 0, 20'h0, 20'h0, 0, low_run, !bus.busy);
      if (bus.err_cfg) check_evt(2, 0, 20'h0, 20'h0, 0, -1, !bus.busy);
    end
    prev_ph = mon_ph;
  end

  task automatic do_write(int a, logic [19:0] d);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'(a); bus.cfg_wdata = d;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    model_tbl[2'(a)] = d;
  endtask

  task automatic do_start(int num, int cl, int slen, int rdly, int ab_pulse, int ab_len,
                          bit wr, int wa, logic [19:0] wd);
    @(negedge clk);
    bus.num_scans = 16'(num); bus.cycle_len = 3'(cl);
    bus.scan_len  = 32'(slen); bus.rep_delay = 32'(rdly);
    bus.start = 1'b1;
    if (wr) begin
      bus.cfg_we = 1'b1; bus.cfg_addr = 2'(wa); bus.cfg_wdata = wd;
      model_tbl[2'(wa)] = wd;
    end
    model_seq(num, cl, slen, rdly, ab_pulse, ab_len);
    @(negedge clk);
    bus.start = 1'b0; bus.cfg_we = 1'b0;
    chk("busy_after_start", longint'(bus.busy), longint'(slen != 0 && num != 0));
  endtask

  task automatic run(int num, int cl, int slen, int rdly);
    do_start(num, cl, slen, rdly, -1, 0, 1'b0, 0, 20'h0);
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (exp_q.size() != 0 || bus.busy) begin
      errors++;
      $display("FAIL seq_timeout pending=%0d busy=%0d expected pending=0 busy=0", exp_q.size(), bus.busy);
      exp_q.delete();
    end
  endtask

  task automatic wait_en(int budget);
    int n = 0;
    while (!bus.enable_PC && n < budget) begin
      @(negedge clk); #1; n++;
    end
    chk("wait_enable_high", longint'(bus.enable_PC), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish expected finish");
    $fatal(1);
  end

  initial begin
    int hi, pulses, n;
    bit prev_en;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.num_scans = '0; bus.cycle_len = '0; bus.scan_len = '0; bus.rep_delay = '0;
    bus.start = 1'b0; bus.abort = 1'b0;
    model_tbl = '{default: '0};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_enable", longint'(bus.enable_PC), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_scan_idx", longint'(bus.scan_idx), 0);
    chk("rst_phase", longint'({bus.TX_phase_data, bus.RX_phase_data}), 0);
    chk("rst_done_err", longint'({bus.done, bus.err_cfg}), 0);
    mon_en = 1'b1;

    // Table A..D, 6 scans of 10 with 6-cycle gaps
    for (int i = 0; i < 4; i++) do_write(i, 20'($urandom));
    run(6, 4, 10, 5);                 wait_idle(500);
    // Single scan; back-to-back scans separated by ARM only
    run(1, 4, 3, 0);                  wait_idle(100);
    run(3, 4, 4, 0);                  wait_idle(100);
    // Bad config and empty sequence
    run(2, 4, 0, 3);                  wait_idle(20);
    run(0, 4, 5, 3);                  wait_idle(20);
    // cycle_len above depth clamps; cycle_len 0 acts as 1
    run(6, 7, 2, 1);                  wait_idle(200);
    run(3, 0, 2, 2);                  wait_idle(200);
    // Write landing in the same cycle as start is used for scan 0
    do_start(2, 2, 3, 1, -1, 0, 1'b1, 0, 20'($urandom)); wait_idle(100);

    // Abort during the 4th high cycle of scan 2
    do_start(4, 4, 8, 3, 1, 4, 1'b0, 0, 20'h0);
    hi = 0; pulses = 0; n = 0; prev_en = 1'b0;
    while (n < 300 && !(pulses == 2 && hi == 4)) begin
      @(negedge clk); #1; n++;
      if (bus.enable_PC) begin
        if (!prev_en) pulses++;
        if (pulses == 2) hi++;
      end
      prev_en = bus.enable_PC;
    end
    chk("abort_point_reached", longint'(hi), 4);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    #1;
    chk("abort_enable_low", longint'(bus.enable_PC), 0);
    chk("abort_busy_low", longint'(bus.busy), 0);
    repeat (10) @(negedge clk);
    chk("abort_no_pending", longint'(exp_q.size()), 0);
    run(2, 4, 3, 1);                  wait_idle(100);

    // abort together with start: start dropped
    @(negedge clk);
    bus.num_scans = 16'd2; bus.scan_len = 32'd3; bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    #1;
    chk("abort_start_busy", longint'(bus.busy), 0);
    repeat (4) @(negedge clk);

    // Table write and second start while running are ignored
    run(3, 4, 6, 2);
    wait_en(50);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_wdata = ~model_tbl[0];
    bus.num_scans = 16'd9; bus.scan_len = 32'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.cfg_we = 1'b0; bus.start = 1'b0;
    wait_idle(200);
    run(1, 1, 2, 0);                  wait_idle(50);

    // Randomized sequences
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 1) == 1) do_write(int'($urandom_range(0, 3)), 20'($urandom));
      run(int'($urandom_range(0, 5)), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
      wait_idle(500);
    end

    // Asynchronous reset mid-scan
    run(3, 4, 20, 2);
    wait_en(50);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_enable", longint'(bus.enable_PC), 0);
    chk("arst_busy", longint'(bus.busy), 0);
    chk("arst_scan_idx", longint'(bus.scan_idx), 0);
    chk("arst_phase", longint'({bus.TX_phase_data, bus.RX_phase_data}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_tbl = '{default: '0};
    @(negedge clk); #1;
    chk("arst_idle_after", longint'(bus.busy), 0);
    mon_en = 1'b1;
    run(3, 4, 3, 1);                  wait_idle(100);

    chk("end_queue_empty", longint'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
